mem_arbiter: RTL and testbench

- Sits between the I-cache and D-cache fill controllers and the single shared multi-cycle main memory.
- Grants memory ownership to one cache at a time and forwards the owner's address and write data to memory.
- Returns memory read data with a valid strobe.
- Feeds the memory stage's cache controller through its service, data_valid and data_from_mem inputs. The same outputs also feed the fetch stage's I-cache.

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: grants the shared main memory to the I-cache or D-cache.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_busy,
  input  logic [15:0] i_addr,
  input  logic        d_busy,
  input  logic [15:0] d_addr,
  input  logic        d_write,
  input  logic [15:0] d_wdata,
  output logic        i_service,
  output logic        d_service,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_data,
  input  logic        mem_valid
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_OUT);

  if (LATENCY < 1 || MAX_OUT < 1 || (2 ** CNT_W) <= MAX_OUT) begin : g_param_check
    $error("mem_arbiter: illegal LATENCY/MAX_OUT/CNT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_I = 2'd1,
    SERV_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             owner_busy;
  logic             cnt_zero;
  logic             rd_accept;
  logic             rd_return;
  state_t           next_grant;

  assign i_service = (state_q == SERV_I);
  assign d_service = (state_q == SERV_D);
  assign cnt_zero  = (out_cnt_q == '0);

  assign owner_busy = (i_service & i_busy) | (d_service & d_busy);
  assign mem_wr     = d_service & d_write;
  assign mem_en     = owner_busy & ((out_cnt_q < CAP) | mem_wr);
  assign mem_addr   = i_service ? i_addr : (d_service ? d_addr : 16'h0000);
  assign mem_wdata  = (i_service | d_service) ? d_wdata : 16'h0000;

  // A return with nothing in flight is a stale pulse from before a reset.
  assign rd_accept  = mem_en & ~mem_wr;
  assign rd_return  = mem_valid & ~cnt_zero;
  assign data_valid = rd_return;
  assign data_out   = rd_return ? mem_data : 16'h0000;

  assign next_grant = d_busy ? SERV_D : (i_busy ? SERV_I : IDLE);

  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;

    if (rd_accept && !rd_return) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!rd_accept && rd_return) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: state_d = next_grant;
      SERV_I, SERV_D: begin
        if (!owner_busy && cnt_zero) begin
          state_d = next_grant;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: randomized scoreboard bench with a memory model.         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int LATENCY = 4;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_busy = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        d_busy = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic        d_write = 1'b0;
  logic [15:0] d_wdata = 16'h0000;
  logic        i_service, d_service, data_valid, mem_en, mem_wr;
  logic [15:0] data_out, mem_addr, mem_wdata;
  logic [15:0] mem_data = 16'h0000;
  logic        mem_valid = 1'b0;

  mem_arbiter #(.LATENCY(LATENCY), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_busy(i_busy), .i_addr(i_addr),
    .d_busy(d_busy), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .i_service(i_service), .d_service(d_service),
    .data_out(data_out), .data_valid(data_valid),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Main memory: in-order reads returning mem_lat cycles after acceptance.
  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t mem_pipe[$];
  int   cyc      = 0;
  int   mem_lat  = LATENCY;
  int   last_due = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_pipe.size() > 0 && mem_pipe[0].due <= cyc) begin
      mem_valid = 1'b1;
      mem_data  = mem_pipe[0].data;
      void'(mem_pipe.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_data  = 16'($urandom);
    end
  end

  initial forever begin
    int due;
    @(negedge clk);
    if (!rst && mem_en && !mem_wr) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_pipe.push_back('{due, mem_fn(mem_addr)});
    end
  end

  // Reference model: owner (0 none, 1 I, 2 D), reads in flight, expected returns.
  typedef struct { int owner; logic [15:0] data; } sb_t;
  sb_t sb_q[$];
  int  m_owner = 0;
  int  m_out   = 0;

  initial forever begin
    logic        ob, e_wr, e_en, e_dv, release_now;
    logic [15:0] e_addr, e_wdata;
    @(negedge clk);
    if (rst) begin
      m_owner = 0;
      m_out   = 0;
      sb_q.delete();
      check("rst_i_service", {15'b0, i_service}, 16'h0);
      check("rst_d_service", {15'b0, d_service}, 16'h0);
      check("rst_mem_en", {15'b0, mem_en}, 16'h0);
      check("rst_mem_wr", {15'b0, mem_wr}, 16'h0);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_mem_wdata", mem_wdata, 16'h0);
      check("rst_data_valid", {15'b0, data_valid}, 16'h0);
      check("rst_data_out", data_out, 16'h0);
    end else begin
      ob      = (m_owner == 1) ? i_busy : ((m_owner == 2) ? d_busy : 1'b0);
      e_wr    = (m_owner == 2) && d_write;
      e_en    = ob && ((m_out < MAX_OUT) || e_wr);
      e_addr  = (m_owner == 1) ? i_addr : ((m_owner == 2) ? d_addr : 16'h0);
      e_wdata = (m_owner != 0) ? d_wdata : 16'h0;
      e_dv    = mem_valid && (m_out > 0);
      check("i_service", {15'b0, i_service}, {15'b0, (m_owner == 1)});
      check("d_service", {15'b0, d_service}, {15'b0, (m_owner == 2)});
      check("mem_en", {15'b0, mem_en}, {15'b0, e_en});
      check("mem_wr", {15'b0, mem_wr}, {15'b0, e_wr});
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("data_valid", {15'b0, data_valid}, {15'b0, e_dv});
      check("data_out", data_out, e_dv ? mem_data : 16'h0);
      release_now = (m_owner == 0) || (!ob && m_out == 0);
      if (e_en && !e_wr) begin
        sb_q.push_back('{m_owner, mem_fn(e_addr)});
        m_out++;
      end
      if (e_dv) m_out--;
      if (release_now) m_owner = d_busy ? 2 : (i_busy ? 1 : 0);
    end
  end

  // Return monitor: every data_valid must match the oldest outstanding read.
  initial forever begin
    sb_t s;
    @(negedge clk);
    if (!rst && data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL return_unexpected: got data %h, expected no return", data_out);
      end else begin
        s = sb_q.pop_front();
        check("return_data", data_out, s.data);
        check("return_owner", {14'b0, d_service, i_service}, 16'(s.owner));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic i_burst(input int n, input logic [15:0] base);
    int   acc = 0;
    int   guard = 0;
    logic hit;
    i_busy = 1'b1;
    i_addr = base;
    while (acc < n && guard < 200) begin
      @(negedge clk);
      hit = i_service && mem_en;
      tick();
      guard++;
      if (hit) begin
        acc++;
        i_addr = i_addr + 16'd2;
      end
    end
    if (acc < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL i_burst_timeout: got %0d accepts, expected %0d", acc, n);
    end
    i_busy = 1'b0;
  endtask

  task automatic d_burst(input int n, input logic [15:0] base, input logic wr, input logic [15:0] wd);
    int   acc = 0;
    int   guard = 0;
    logic hit;
    d_busy  = 1'b1;
    d_addr  = base;
    d_write = wr;
    d_wdata = wd;
    while (acc < n && guard < 200) begin
      @(negedge clk);
      hit = d_service && mem_en;
      tick();
      guard++;
      if (hit) begin
        acc++;
        d_addr = d_addr + 16'd2;
      end
    end
    if (acc < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL d_burst_timeout: got %0d accepts, expected %0d", acc, n);
    end
    d_busy  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(m_owner == 0 && m_out == 0 && mem_pipe.size() == 0) && guard < 100) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL drain_timeout: got owner %0d outstanding %0d, expected 0 and 0", m_owner, m_out);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    i_burst(4, 16'h0010);
    wait_idle();

    fork
      i_burst(3, 16'h0100);
      d_burst(3, 16'h0200, 1'b0, 16'h0000);
    join
    wait_idle();

    d_burst(1, 16'h8000, 1'b1, 16'hBEEF);
    wait_idle();

    fork
      d_burst(2, 16'h0400, 1'b0, 16'h0000);
      i_burst(2, 16'h0500);
    join
    wait_idle();

    mem_lat = 6;
    i_burst(10, 16'h0600);
    wait_idle();
    mem_lat = LATENCY;

    i_burst(3, 16'h0700);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    wait_idle();

    repeat (400) begin
      i_busy  = ($urandom_range(0, 3) != 0);
      d_busy  = ($urandom_range(0, 2) == 0);
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_write = 1'($urandom_range(0, 1));
      d_wdata = 16'($urandom);
      mem_lat = LATENCY + int'($urandom_range(0, 2));
      tick();
    end
    i_busy  = 1'b0;
    d_busy  = 1'b0;
    d_write = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
